pixel_fetch: RTL
================

PIXEL_FETCH -- requirements
Module: pixel_fetch

Interface
REQ-001 Parameter H_ACTIVE, 480, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, 2 / 41 / 2, horizontal porch and sync widths in clocks (H_TOTAL = sum = 525).
REQ-003 Parameter V_ACTIVE, 272, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, 2 / 10 / 2, vertical porch and sync widths in lines (V_TOTAL = 286).
REQ-005 Parameter SCALE_SHIFT, 1, pixel replication factor 2^SCALE_SHIFT in x and y (0..3).
REQ-006 Parameter IMG_W_LOG2 / IMG_H_LOG2, 8 / 7, stored image size 2^W x 2^H source pixels.
REQ-007 Parameter BPP, 2, colour index width.
REQ-008 Parameter ROM_LAT, 1, clocks from o_addr valid to i_data valid (1..4).
REQ-009 Parameter SYNC_ACT, 0, asserted level of o_hsync/o_vsync.
REQ-010 i_clk  in  1  pixel clock; single clock domain.
REQ-011 i_rst  in  1  synchronous, active-high reset.
REQ-012 i_border  in  BPP  index driven for active pixels outside the image.
REQ-013 i_pal  in  1  palette select request.
REQ-014 o_addr  out  IMG_H_LOG2+IMG_W_LOG2  memory address {row, col}.
REQ-015 i_data  in  BPP  memory read data, ROM_LAT clocks after o_addr.
REQ-016 o_hsync, o_vsync, o_den  out  1 each  panel timing, aligned to o_index.
REQ-017 o_index  out  BPP  colour index for the palette stage.
REQ-018 o_pal  out  1  palette select, frame-stable.
REQ-019 o_sof  out  1  one-clock start-of-frame pulse, aligned to first active pixel of o_index.

Function
REQ-020 Counter hc SHALL count 0..H_TOTAL-1 and wrap to 0; vc SHALL increment when hc wraps and wrap to 0 after V_TOTAL-1.
REQ-021 Line order SHALL be active, front porch, sync, back porch; same for frame with vc.
REQ-022 Raw hsync SHALL be SYNC_ACT for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC; raw vsync likewise on vc; raw den SHALL be 1 iff hc<H_ACTIVE and vc<V_ACTIVE.
REQ-023 col = hc>>SCALE_SHIFT, row = vc>>SCALE_SHIFT; in_img SHALL be 1 iff raw den and col<2^IMG_W_LOG2 and row<2^IMG_H_LOG2.
REQ-024 o_addr SHALL be registered {row[IMG_H_LOG2-1:0], col[IMG_W_LOG2-1:0]} when in_img, else hold 0; one clock after counters.
REQ-025 Raw hsync, vsync, den, in_img, sof SHALL pass through a shift pipeline of exactly ROM_LAT+1 stages so all outputs align with i_data for that pixel.
REQ-026 o_index SHALL equal i_data when delayed in_img=1, i_border when delayed den=1 and in_img=0, else 0.
REQ-027 o_pal SHALL load i_pal only on the clock where hc=0 and vc=0; i_pal changes mid-frame SHALL not affect the current frame.
REQ-028 Raw sof SHALL be 1 only at hc=0, vc=0.
REQ-029 Total latency counter-to-output SHALL be ROM_LAT+1 clocks; no other buffering.
REQ-030 Widths of hc/vc SHALL be clog2 of H_TOTAL/V_TOTAL; no overflow past TOTAL-1 permitted.

Reset
REQ-031 On i_rst=1 at a clock edge: hc=0, vc=0, all pipeline stages cleared, o_addr=0, o_index=0, o_den=0, o_sof=0, o_pal=0, o_hsync=o_vsync=~SYNC_ACT.
REQ-032 Reset mid-frame SHALL abort the frame; first clock after release is hc=0,vc=0 and o_sof SHALL assert exactly ROM_LAT+1 clocks later.
REQ-033 During pipeline refill after reset, outputs SHALL show cleared (inactive) values, never stale data.

Verification
REQ-034 Defaults, release reset, run 2 frames -> o_hsync low 41 clocks every 525; o_vsync low 10 lines every 286 lines; o_den high 480x272 per frame.
REQ-035 Defaults, ROM model returns addr[1:0] after 1 clock -> o_index at pixel (x=5,y=3) equals ((1<<8|2)&3)=2; each source pixel repeated 2x2.
REQ-036 Defaults, i_border=3 -> all active pixels with vc>=256 show o_index=3; blanking shows 0.
REQ-037 ROM_LAT=3 -> o_sof, o_den rising edge and first ROM data coincide, 4 clocks after hc=0,vc=0.
REQ-038 Toggle i_pal at line 100 -> o_pal changes only at next frame start, in same clock as next raw sof.
REQ-039 Assert i_rst at hc=300,vc=150 for 1 clock -> outputs cleared next clock, o_sof pulses 2 clocks after release, sequence restarts.

Source files
------------

// File: rtl/pixel_fetch.sv
// pixel_fetch: panel timing generator with an image-fetch address stage.
// Counters walk the raster, raw timing flags are derived from them, the
// image address is registered toward an external memory, and the timing
// flags ride a ROM_LAT+1 deep shift pipeline so they leave in the same
// clock as the memory data for that pixel.
module pixel_fetch #(
  parameter int   H_ACTIVE    = 480,
  parameter int   H_FP        = 2,
  parameter int   H_SYNC      = 41,
  parameter int   H_BP        = 2,
  parameter int   V_ACTIVE    = 272,
  parameter int   V_FP        = 2,
  parameter int   V_SYNC      = 10,
  parameter int   V_BP        = 2,
  parameter int   SCALE_SHIFT = 1,
  parameter int   IMG_W_LOG2  = 8,
  parameter int   IMG_H_LOG2  = 7,
  parameter int   BPP         = 2,
  parameter int   ROM_LAT     = 1,
  parameter logic SYNC_ACT    = 1'b0
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [BPP-1:0]                   i_border,
  input  logic                             i_pal,
  output logic [IMG_H_LOG2+IMG_W_LOG2-1:0] o_addr,
  input  logic [BPP-1:0]                   i_data,
  output logic                             o_hsync,
  output logic                             o_vsync,
  output logic                             o_den,
  output logic [BPP-1:0]                   o_index,
  output logic                             o_pal,
  output logic                             o_sof
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int AW      = IMG_H_LOG2 + IMG_W_LOG2;
  // Timing flags are delayed by the address register plus the memory latency.
  localparam int DEPTH   = ROM_LAT + 1;

  localparam logic [HC_W-1:0] HC_LAST     = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] HC_ACT_END  = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] HC_SYNC_BEG = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] HC_SYNC_END = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0] VC_LAST     = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] VC_ACT_END  = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] VC_SYNC_BEG = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] VC_SYNC_END = VC_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [HC_W-1:0]  hc;
  logic [VC_W-1:0]  vc;

  logic             raw_den;
  logic             raw_hs_act;
  logic             raw_vs_act;
  logic             raw_sof;
  logic             raw_in_img;
  logic [31:0]      col_full;
  logic [31:0]      row_full;
  logic [AW-1:0]    raw_addr;

  // Sync flags are carried as "asserted" bits; polarity is applied at the pins.
  logic [DEPTH-1:0] den_pipe;
  logic [DEPTH-1:0] hs_pipe;
  logic [DEPTH-1:0] vs_pipe;
  logic [DEPTH-1:0] img_pipe;
  logic [DEPTH-1:0] sof_pipe;

  // Raster counters: hc wraps every line, vc advances on hc wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == HC_LAST) begin
      hc <= '0;
      if (vc == VC_LAST) begin
        vc <= '0;
      end else begin
        vc <= vc + 1'b1;
      end
    end else begin
      hc <= hc + 1'b1;
    end
  end

  // Raw timing and image-window decode straight from the counters.
  always_comb begin
    raw_den    = (hc < HC_ACT_END) && (vc < VC_ACT_END);
    raw_hs_act = (hc >= HC_SYNC_BEG) && (hc < HC_SYNC_END);
    raw_vs_act = (vc >= VC_SYNC_BEG) && (vc < VC_SYNC_END);
    raw_sof    = (hc == '0) && (vc == '0);
    col_full   = 32'(hc) >> SCALE_SHIFT;
    row_full   = 32'(vc) >> SCALE_SHIFT;
    raw_in_img = raw_den
                 && ((col_full >> IMG_W_LOG2) == 32'd0)
                 && ((row_full >> IMG_H_LOG2) == 32'd0);
    raw_addr   = {row_full[IMG_H_LOG2-1:0], col_full[IMG_W_LOG2-1:0]};
  end

  // Address register: parks at 0 outside the image so the memory sees no churn.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_addr <= '0;
    end else if (raw_in_img) begin
      o_addr <= raw_addr;
    end else begin
      o_addr <= '0;
    end
  end

  // Timing flag delay line, cleared on reset so refill never shows stale flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      den_pipe <= '0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
      img_pipe <= '0;
      sof_pipe <= '0;
    end else begin
      den_pipe <= {den_pipe[DEPTH-2:0], raw_den};
      hs_pipe  <= {hs_pipe[DEPTH-2:0],  raw_hs_act};
      vs_pipe  <= {vs_pipe[DEPTH-2:0],  raw_vs_act};
      img_pipe <= {img_pipe[DEPTH-2:0], raw_in_img};
      sof_pipe <= {sof_pipe[DEPTH-2:0], raw_sof};
    end
  end

  // Palette select is captured once per frame, at the raster origin.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pal <= 1'b0;
    end else if (raw_sof) begin
      o_pal <= i_pal;
    end
  end

  // Output stage: i_data arrives this clock for the pixel at the pipe end,
  // so the index mux is combinational to keep total latency at ROM_LAT+1.
  always_comb begin
    o_den   = den_pipe[DEPTH-1];
    o_sof   = sof_pipe[DEPTH-1];
    o_hsync = hs_pipe[DEPTH-1] ? SYNC_ACT : ~SYNC_ACT;
    o_vsync = vs_pipe[DEPTH-1] ? SYNC_ACT : ~SYNC_ACT;
    if (img_pipe[DEPTH-1]) begin
      o_index = i_data;
    end else if (den_pipe[DEPTH-1]) begin
      o_index = i_border;
    end else begin
      o_index = '0;
    end
  end

endmodule
